// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slew-limited duty/direction sequencer for one PWM channel.
// Speed commands ramp pwm_val by STEP per tick; reversals pass through zero and a dead-time.
module pwm_ramp_ctrl #(
    parameter int TICK_DIV       = 5000,
    parameter int STEP           = 4,
    parameter int DEADTIME_TICKS = 8,
    parameter int WDOG_TICKS     = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic signed [8:0] cmd_speed,
    output logic [7:0]        pwm_val,
    output logic              dir,
    output logic              busy,
    output logic              timeout,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RAMP = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEADTIME_TICKS + 1);
    localparam int WW = $clog2(WDOG_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_TICKS - 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_TICKS - 1);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_TICKS);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] dead_cnt;
    logic [WW-1:0] wdog_cnt;
    logic [7:0]    tgt_mag;
    logic          tgt_dir;

    logic          tick;
    logic          accept;
    logic          fire;
    logic          mismatch;
    logic [8:0]    neg_mag;
    logic [7:0]    cmd_mag;
    logic          cmd_dir;
    logic [8:0]    goal;
    logic [8:0]    cur;
    logic [8:0]    diff;
    logic [8:0]    step_pwm;
    state_t        ramp_next;

    // Handshake: a command transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready drops only during the dead-time.
    assign cmd_ready = (state != DEAD);
    assign busy      = (state != HOLD);
    assign state_dbg = state;
    assign tick      = (tick_cnt == TICK_LAST);
    assign accept    = cmd_valid & cmd_ready;
    assign fire      = tick & ~accept & (wdog_cnt == WDOG_LAST);
    assign mismatch  = (pwm_val != tgt_mag) | (dir != tgt_dir);

    always_comb begin
        neg_mag   = 9'd0 - cmd_speed;
        cmd_mag   = cmd_speed[7:0];
        cmd_dir   = ~cmd_speed[8];
        goal      = {1'b0, tgt_mag};
        cur       = {1'b0, pwm_val};
        diff      = 9'd0;
        step_pwm  = cur;
        ramp_next = RAMP;
        if (cmd_speed[8]) begin
            cmd_mag = neg_mag[8] ? 8'hff : neg_mag[7:0];
        end
        if (cmd_speed == 9'sd0) begin
            cmd_dir = dir;
        end
        // While the direction is wrong the only legal goal is zero duty.
        if (dir != tgt_dir) begin
            goal = 9'd0;
        end
        diff = (goal >= cur) ? (goal - cur) : (cur - goal);
        if (diff <= STEP9) begin
            step_pwm = goal;
        end else if (goal > cur) begin
            step_pwm = cur + STEP9;
        end else begin
            step_pwm = cur - STEP9;
        end
        if (dir != tgt_dir) begin
            ramp_next = (step_pwm == 9'd0) ? DEAD : RAMP;
        end else begin
            ramp_next = (step_pwm == goal) ? HOLD : RAMP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HOLD;
            tick_cnt <= '0;
            dead_cnt <= '0;
            wdog_cnt <= '0;
            tgt_mag  <= 8'd0;
            tgt_dir  <= 1'b1;
            pwm_val  <= 8'd0;
            dir      <= 1'b1;
            timeout  <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            // An accept in the same cycle as a watchdog expiry wins.
            if (accept) begin
                tgt_mag  <= cmd_mag;
                tgt_dir  <= cmd_dir;
                wdog_cnt <= '0;
                timeout  <= 1'b0;
            end else if (tick) begin
                if (wdog_cnt != WDOG_MAX) begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
                if (fire) begin
                    timeout <= 1'b1;
                    tgt_mag <= 8'd0;
                    tgt_dir <= dir;
                end
            end

            case (state)
                HOLD: begin
                    if (mismatch) begin
                        if (tick) begin
                            pwm_val <= step_pwm[7:0];
                            state   <= ramp_next;
                        end else begin
                            state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (tick) begin
                        pwm_val <= step_pwm[7:0];
                        state   <= ramp_next;
                    end
                end
                DEAD: begin
                    if (tick) begin
                        if (fire) begin
                            dead_cnt <= '0;
                            state    <= HOLD;
                        end else if (dead_cnt == DEAD_LAST) begin
                            dead_cnt <= '0;
                            dir      <= ~dir;
                            state    <= RAMP;
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed scenarios plus randomized commands
// compared cycle by cycle against a tick-level behavioural model.
module tb_pwm_ramp_ctrl;
    localparam int TD = 4;
    localparam int ST = 4;
    localparam int DT = 2;
    localparam int WD = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic signed [8:0] cmd_speed = 9'sd0;
    logic [7:0]        pwm_val;
    logic              dir;
    logic              busy;
    logic              timeout;
    logic [1:0]        state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 settled, 1 moving, 2 dead-time.
    int m_pwm, m_tmag, m_phase, m_dead, m_wd, m_cnt;
    bit m_dir, m_tdir, m_to, m_tick;

    pwm_ramp_ctrl #(
        .TICK_DIV(TD), .STEP(ST), .DEADTIME_TICKS(DT), .WDOG_TICKS(WD)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_speed(cmd_speed), .pwm_val(pwm_val), .dir(dir), .busy(busy),
        .timeout(timeout), .state_dbg(state_dbg)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic model_reset();
        m_pwm = 0; m_tmag = 0; m_phase = 0; m_dead = 0; m_wd = 0; m_cnt = 0;
        m_dir = 1'b1; m_tdir = 1'b1; m_to = 1'b0; m_tick = 1'b0;
    endtask

    // Advances the model by one clock using the inputs currently driven.
    task automatic model_edge();
        int sp, goal, d;
        bit acc, tk, fire, moving, od;
        sp     = cmd_speed;
        od     = m_dir;
        acc    = cmd_valid && (m_phase != 2);
        tk     = (m_cnt == TD - 1);
        fire   = tk && !acc && (m_wd == WD - 1);
        moving = (m_pwm != m_tmag) || (m_dir != m_tdir);
        if (tk) begin
            if (m_phase == 2) begin
                if (fire) begin
                    m_phase = 0; m_dead = 0;
                end else if (m_dead == DT - 1) begin
                    m_dir = !m_dir; m_phase = 1; m_dead = 0;
                end else begin
                    m_dead++;
                end
            end else if (m_phase == 1 || moving) begin
                goal = (m_dir != m_tdir) ? 0 : m_tmag;
                d = goal - m_pwm;
                if (d < 0) d = -d;
                if (d <= ST) m_pwm = goal;
                else m_pwm = m_pwm + ((goal > m_pwm) ? ST : -ST);
                if (m_dir != m_tdir) m_phase = (m_pwm == 0) ? 2 : 1;
                else m_phase = (m_pwm == m_tmag) ? 0 : 1;
            end
        end else if (m_phase == 0 && moving) begin
            m_phase = 1;
        end
        if (acc) begin
            if (sp == 0) begin
                m_tmag = 0; m_tdir = od;
            end else if (sp < 0) begin
                m_tmag = (-sp > 255) ? 255 : -sp; m_tdir = 1'b0;
            end else begin
                m_tmag = sp; m_tdir = 1'b1;
            end
            m_wd = 0; m_to = 1'b0;
        end else if (tk) begin
            if (m_wd < WD) m_wd++;
            if (fire) begin
                m_to = 1'b1; m_tmag = 0; m_tdir = od;
            end
        end
        m_cnt  = tk ? 0 : m_cnt + 1;
        m_tick = tk;
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < TD + 1; i++) begin
            clk_step();
            if (m_tick) break;
        end
    endtask

    task automatic send(input int sp);
        bit was_ready, done;
        done = 1'b0;
        cmd_speed = 9'(sp);
        cmd_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            was_ready = cmd_ready;
            clk_step();
            if (was_ready) done = 1'b1;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL send_accept: command %0d not accepted within 64 cycles", sp);
        end
    endtask

    // Re-sends the command every few ticks so the watchdog stays quiet on long ramps.
    task automatic drive_until_settled(input int sp);
        bit done;
        done = 1'b0;
        for (int r = 0; r < 40 && !done; r++) begin
            send(sp);
            for (int i = 0; i < 6 && !done; i++) begin
                wait_tick();
                if (m_phase == 0) done = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 5;
        if (pwm_val !== 8'd0) begin n_bad++; $display("FAIL reset_pwm: got %0d expected 0", pwm_val); end
        if (dir !== 1'b1) begin n_bad++; $display("FAIL reset_dir: got %b expected 1", dir); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        release_reset();
    endtask

    task automatic test_ramp_up();
        send(20);
        clk_step();
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL ramp_busy_rise: got %b expected 1", busy); end
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            n_cmp += 3;
            if (pwm_val !== 8'(4 * k)) begin n_bad++; $display("FAIL ramp_pwm[%0d]: got %0d expected %0d", k, pwm_val, 4 * k); end
            if (dir !== 1'b1) begin n_bad++; $display("FAIL ramp_dir[%0d]: got %b expected 1", k, dir); end
            if (busy !== (k < 5)) begin n_bad++; $display("FAIL ramp_busy[%0d]: got %b expected %b", k, busy, k < 5); end
        end
    endtask

    task automatic test_reversal();
        send(-10);
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            n_cmp++;
            if (pwm_val !== 8'(20 - 4 * k)) begin n_bad++; $display("FAIL rev_down[%0d]: got %0d expected %0d", k, pwm_val, 20 - 4 * k); end
        end
        n_cmp += 2;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rev_dead_ready: got %b expected 0", cmd_ready); end
        if (dir !== 1'b1) begin n_bad++; $display("FAIL rev_dead_dir0: got %b expected 1", dir); end
        cmd_speed = 9'sd100;
        cmd_valid = 1'b1;
        wait_tick();
        n_cmp += 2;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rev_dead_ready1: got %b expected 0", cmd_ready); end
        if (dir !== 1'b1) begin n_bad++; $display("FAIL rev_dead_dir1: got %b expected 1", dir); end
        wait_tick();
        cmd_valid = 1'b0;
        n_cmp += 3;
        if (dir !== 1'b0) begin n_bad++; $display("FAIL rev_dir_flip: got %b expected 0", dir); end
        if (pwm_val !== 8'd0) begin n_bad++; $display("FAIL rev_flip_pwm: got %0d expected 0", pwm_val); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rev_ready_back: got %b expected 1", cmd_ready); end
        for (int k = 1; k <= 3; k++) begin
            wait_tick();
            n_cmp++;
            if (pwm_val !== 8'((k == 3) ? 10 : 4 * k)) begin
                n_bad++; $display("FAIL rev_up[%0d]: got %0d expected %0d", k, pwm_val, (k == 3) ? 10 : 4 * k);
            end
        end
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rev_busy_end: got %b expected 0", busy); end
        if (dir !== 1'b0) begin n_bad++; $display("FAIL rev_dir_end: got %b expected 0", dir); end
    endtask

    task automatic test_watchdog();
        send(20);
        for (int t = 1; t <= 16; t++) begin
            wait_tick();
            if (t == 15) begin
                n_cmp++;
                if (timeout !== 1'b0) begin n_bad++; $display("FAIL wdog_early: got %b expected 0", timeout); end
            end
        end
        n_cmp += 3;
        if (timeout !== 1'b1) begin n_bad++; $display("FAIL wdog_fire: got %b expected 1", timeout); end
        if (pwm_val !== 8'd20) begin n_bad++; $display("FAIL wdog_pwm_at_fire: got %0d expected 20", pwm_val); end
        if (dir !== 1'b1) begin n_bad++; $display("FAIL wdog_dir_at_fire: got %b expected 1", dir); end
        for (int k = 1; k <= 5; k++) begin
            wait_tick();
            n_cmp += 2;
            if (pwm_val !== 8'(20 - 4 * k)) begin n_bad++; $display("FAIL wdog_down[%0d]: got %0d expected %0d", k, pwm_val, 20 - 4 * k); end
            if (dir !== 1'b1) begin n_bad++; $display("FAIL wdog_dir[%0d]: got %b expected 1", k, dir); end
        end
        send(8);
        n_cmp++;
        if (timeout !== 1'b0) begin n_bad++; $display("FAIL wdog_clear: got %b expected 0", timeout); end
    endtask

    task automatic test_saturation();
        drive_until_settled(-256);
        n_cmp += 3;
        if (pwm_val !== 8'd255) begin n_bad++; $display("FAIL sat_pwm: got %0d expected 255", pwm_val); end
        if (dir !== 1'b0) begin n_bad++; $display("FAIL sat_dir: got %b expected 0", dir); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL sat_busy: got %b expected 0", busy); end
        drive_until_settled(0);
        n_cmp += 2;
        if (pwm_val !== 8'd0) begin n_bad++; $display("FAIL zero_pwm: got %0d expected 0", pwm_val); end
        if (dir !== 1'b0) begin n_bad++; $display("FAIL zero_keeps_dir: got %b expected 0", dir); end
        drive_until_settled(4);
        drive_until_settled(0);
        n_cmp += 2;
        if (pwm_val !== 8'd0) begin n_bad++; $display("FAIL fwd_zero_pwm: got %0d expected 0", pwm_val); end
        if (dir !== 1'b1) begin n_bad++; $display("FAIL fwd_zero_dir: got %b expected 1", dir); end
        send(3);
        wait_tick();
        n_cmp += 2;
        if (pwm_val !== 8'd3) begin n_bad++; $display("FAIL small_step_pwm: got %0d expected 3", pwm_val); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL small_step_busy: got %b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        do_reset();
        release_reset();
        send(20);
        for (int k = 0; k < 3; k++) wait_tick();
        n_cmp++;
        if (pwm_val !== 8'd12) begin n_bad++; $display("FAIL arst_pre_pwm: got %0d expected 12", pwm_val); end
        clk_step();
        #2;
        reset = 1'b0;
        #1;
        n_cmp += 5;
        if (pwm_val !== 8'd0) begin n_bad++; $display("FAIL arst_pwm: got %0d expected 0", pwm_val); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b expected 0", busy); end
        if (dir !== 1'b1) begin n_bad++; $display("FAIL arst_dir: got %b expected 1", dir); end
        if (timeout !== 1'b0) begin n_bad++; $display("FAIL arst_timeout: got %b expected 0", timeout); end
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b expected 1", cmd_ready); end
        @(posedge clk);
        #1;
        release_reset();
        send(8);
        clk_step();
        clk_step();
        n_cmp += 2;
        if (pwm_val !== 8'd0) begin n_bad++; $display("FAIL arst_tick_early: got %0d expected 0", pwm_val); end
        if (busy !== 1'b1) begin n_bad++; $display("FAIL arst_busy_ramp: got %b expected 1", busy); end
        clk_step();
        n_cmp++;
        if (pwm_val !== 8'd4) begin n_bad++; $display("FAIL arst_tick_restart: got %0d expected 4", pwm_val); end
    endtask

    task automatic test_random();
        int vp, kind, sp;
        for (int seg = 0; seg < 8; seg++) begin
            vp = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 3 : 25);
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 99) < vp) begin
                    kind = $urandom_range(0, 3);
                    case (kind)
                        0: sp = int'($urandom_range(0, 511)) - 256;
                        1: sp = int'($urandom_range(0, 24)) - 12;
                        2: sp = ($urandom_range(0, 2) == 0) ? -256 : (($urandom_range(0, 1) == 0) ? 255 : 0);
                        default: sp = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, ST + 1)) : -int'($urandom_range(1, ST + 1));
                    endcase
                    cmd_speed = 9'(sp);
                    cmd_valid = 1'b1;
                end else begin
                    cmd_valid = 1'b0;
                end
                clk_step();
                n_cmp += 5;
                if (pwm_val !== 8'(m_pwm)) begin n_bad++; $display("FAIL rnd_pwm @%0t: got %0d expected %0d", $time, pwm_val, m_pwm); end
                if (dir !== m_dir) begin n_bad++; $display("FAIL rnd_dir @%0t: got %b expected %b", $time, dir, m_dir); end
                if (busy !== (m_phase != 0)) begin n_bad++; $display("FAIL rnd_busy @%0t: got %b expected %b", $time, busy, m_phase != 0); end
                if (timeout !== m_to) begin n_bad++; $display("FAIL rnd_timeout @%0t: got %b expected %b", $time, timeout, m_to); end
                if (cmd_ready !== (m_phase != 2)) begin n_bad++; $display("FAIL rnd_ready @%0t: got %b expected %b", $time, cmd_ready, m_phase != 2); end
            end
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_reversal();
        test_watchdog();
        test_saturation();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Slew-rate and direction sequencer that sits between the wheel-speed command source and one `Pwm` channel, driving its `pwm_val` and `dir` inputs. It accepts signed speed commands over a valid/ready handshake and ramps the duty value toward the target at a fixed step per ramp tick. On a direction reversal it ramps to zero, holds a dead-time, and then flips `dir`. A command watchdog ramps the motor to zero when commands stop arriving.

## Interface
- `TICK_DIV`, 5000: clocks per ramp tick (≥2).
- `STEP`, 4: maximum `pwm_val` change per tick (1..255).
- `DEADTIME_TICKS`, 8: ticks held at zero duty before `dir` flips (≥1).
- `WDOG_TICKS`, 1000: ticks without an accepted command before the watchdog fires (≥1).

- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block accepts a command this cycle.
- `cmd_speed`  in  9  signed two's-complement speed, range -256..+255.
- `pwm_val`  out  8  duty value to `Pwm`; registered.
- `dir`  out  1  direction to `Pwm`; 1 = forward, 0 = reverse; registered.
- `busy`  out  1  high while state ≠ HOLD.
- `timeout`  out  1  sticky watchdog flag.

## Operation
- Tick generator: a counter runs 0..TICK_DIV-1 and wraps. `tick` is high for one clock when the count equals TICK_DIV-1. Every ramp, dead-time and watchdog action happens only on `tick`.
- Command accept: accepted when `cmd_valid & cmd_ready`.
  - Target direction is taken from the sign of `cmd_speed`.
  - Target magnitude is |`cmd_speed`|. -256 saturates to 255.
  - A speed of 0 sets magnitude 0 and leaves the target direction equal to the current `dir`.
  - Acceptance clears the watchdog count and `timeout`.
  - A later command overwrites the target; no queueing.
- `cmd_ready` is 1 in HOLD and RAMP and 0 in DEAD.
- States and transitions:
  - HOLD: `pwm_val` equals the target magnitude and `dir` matches. Go to RAMP when they mismatch.
  - RAMP, on each tick:
    - If the direction mismatches and `pwm_val` is not 0, step toward 0.
    - If the direction mismatches and `pwm_val` is 0, go to DEAD.
    - Otherwise step toward the target magnitude; go to HOLD when it is reached.
  - DEAD: count DEADTIME_TICKS ticks. On the final tick toggle `dir` and go to RAMP.
- Step arithmetic:
  - Compute in 9 bits. If |target − `pwm_val`| ≤ STEP, load the target; otherwise add or subtract STEP.
  - No wrap-around: `pwm_val` never leaves 0..255.
- Watchdog:
  - Counts ticks since the last accept; the count saturates.
  - On reaching WDOG_TICKS: set `timeout` = 1, force the target magnitude to 0 (target direction = current `dir`), and ramp down normally.
  - If it fires in DEAD: abort to HOLD with no `dir` flip and `pwm_val` = 0.
- Simultaneous events: when an accept and a watchdog fire land in the same cycle, the accept wins and `timeout` stays 0.

## Timing
- Reset values (while `reset` = 0):
  - Outputs: `pwm_val` = 0, `dir` = 1, `busy` = 0, `timeout` = 0, `cmd_ready` = 1.
  - Internal: state = HOLD, target = +0, tick/dead/watchdog counters = 0.
- Asserting reset mid-ramp clears everything immediately, with no clock needed.
- The target updates on the accepting edge. The first `pwm_val` change happens on the edge that samples the next `tick`.
- `pwm_val` and `dir` change only on tick edges. `dir` changes only on the DEAD exit edge, always with `pwm_val` = 0.
- `busy` rises the cycle after an accept that creates a mismatch. It falls on the edge where the final step lands.
- Reversal time from magnitude M to a magnitude N in the opposite direction: ceil(M/STEP) + DEADTIME_TICKS + ceil(N/STEP) ticks.

## Test plan
Bench parameters: TICK_DIV=4, STEP=4, DEADTIME_TICKS=2, WDOG_TICKS=16.
- Reset: hold `reset` = 0 → `pwm_val` = 0, `dir` = 1, `busy` = 0, `timeout` = 0, `cmd_ready` = 1.
- Ramp up: accept +20 → `pwm_val` goes 4, 8, 12, 16, 20 on 5 successive ticks; `busy` falls with the 20; `dir` stays 1.
- Reversal: from +20, accept -10 → `pwm_val` ramps 16…0 in 5 ticks; DEAD for 2 ticks with `cmd_ready` = 0 and `cmd_valid` ignored; `dir` goes 0; `pwm_val` then goes 4, 8, 10.
- Watchdog: hold +20 with no commands → after 16 ticks `timeout` = 1 and `pwm_val` ramps to 0 with `dir` = 1; the next accept clears `timeout`.
- Saturation and small step: accept -256 → ramp ends at `pwm_val` = 255 with `dir` = 0; from 0, accept +3 → `pwm_val` reaches 3 in one tick.
- Async reset mid-ramp: assert `reset` = 0 between clock edges at `pwm_val` = 12 → `pwm_val` = 0 and `busy` = 0 immediately; after release, the tick count restarts from 0.
